// File: rtl/float_vec_stream_packer_pkg.sv
// Shared definitions for the 4-lane vector-stream blocks: lane count,
// lane index/count types and the fill/capture/drain state encoding.
package float_vec_pkg;

    localparam int LANES      = 4;
    localparam int LANE_IDX_W = 2;

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;
    typedef logic [LANE_IDX_W:0]   lane_cnt_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Number of lanes holding data once the lane at last_idx has been written.
    function automatic lane_cnt_t lanes_used(input lane_idx_t last_idx);
        return {1'b0, last_idx} + 3'd1;
    endfunction

endpackage

// File: rtl/float_vec_stream_packer.sv
// Packs scalar (a,b) pairs into 4-lane vectors for an external combinational
// multiplier, registers the product vector and streams it back out one lane at a time.
module float_vec_stream_packer #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_a,
    input  logic [DATA_WIDTH-1:0]       in_b,
    input  logic                        in_last,
    output logic [LANES*DATA_WIDTH-1:0] mult_a,
    output logic [LANES*DATA_WIDTH-1:0] mult_b,
    input  logic [LANES*DATA_WIDTH-1:0] mult_result,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last
);
    import float_vec_pkg::*;

    state_t                      r_state;
    lane_idx_t                   r_lane_idx;
    lane_idx_t                   r_out_idx;
    lane_cnt_t                   r_cnt;
    logic                        r_last_flag;
    logic [LANES*DATA_WIDTH-1:0] r_mult_a;
    logic [LANES*DATA_WIDTH-1:0] r_mult_b;
    logic [LANES*DATA_WIDTH-1:0] r_buf;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic                        r_out_last;
    logic [DATA_WIDTH-1:0]       r_out_data;

    logic      w_in_fire;
    logic      w_out_fire;
    logic      w_lane_full;
    logic      w_drain_end;
    lane_idx_t w_out_idx_nxt;

    assign w_in_fire     = in_valid && r_in_ready;
    assign w_out_fire    = r_out_valid && out_ready;
    assign w_lane_full   = (r_lane_idx == lane_idx_t'(LANES - 1));
    assign w_out_idx_nxt = r_out_idx + 2'd1;
    assign w_drain_end   = ({1'b0, r_out_idx} == (r_cnt - 3'd1));

    // Fill/capture/drain sequencer; every output is driven straight from a register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_lane_idx  <= 2'd0;
            r_out_idx   <= 2'd0;
            r_cnt       <= 3'd0;
            r_last_flag <= 1'b0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_buf       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_in_fire) begin
                        r_mult_a[r_lane_idx*DATA_WIDTH +: DATA_WIDTH] <= in_a;
                        r_mult_b[r_lane_idx*DATA_WIDTH +: DATA_WIDTH] <= in_b;
                        if (w_lane_full || in_last) begin
                            r_state     <= CAPTURE;
                            r_in_ready  <= 1'b0;
                            r_cnt       <= lanes_used(r_lane_idx);
                            r_last_flag <= in_last;
                        end else begin
                            r_lane_idx <= r_lane_idx + 2'd1;
                        end
                    end
                end
                CAPTURE: begin
                    // Multiplier inputs have been stable for this whole cycle.
                    r_buf       <= mult_result;
                    r_out_idx   <= 2'd0;
                    r_out_data  <= mult_result[DATA_WIDTH-1:0];
                    r_out_last  <= r_last_flag && (r_cnt == 3'd1);
                    r_out_valid <= 1'b1;
                    r_state     <= DRAIN;
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_drain_end) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_mult_a    <= '0;
                            r_mult_b    <= '0;
                            r_lane_idx  <= 2'd0;
                            r_in_ready  <= 1'b1;
                            r_state     <= FILL;
                        end else begin
                            r_out_idx  <= w_out_idx_nxt;
                            r_out_data <= r_buf[w_out_idx_nxt*DATA_WIDTH +: DATA_WIDTH];
                            r_out_last <= r_last_flag && ({1'b0, w_out_idx_nxt} == (r_cnt - 3'd1));
                        end
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_lane_idx  <= 2'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule
